// File: rtl/stopwatch_ctrl.sv
// Front-panel sequencer for the 4-digit BCD stopwatch: turns button edges into
// start/stop, lap-freeze, clear and direction commands for the counting datapath.
module stopwatch_ctrl #(
    parameter int unsigned        HOLD_W   = 16,
    parameter logic [HOLD_W-1:0]  LAP_HOLD = '0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_ss,
    input  logic       btn_lap,
    input  logic       btn_clr,
    input  logic       dir_sw,
    input  logic [3:0] d3,
    input  logic [3:0] d2,
    input  logic [3:0] d1,
    input  logic [3:0] d0,
    output logic       go,
    output logic       up,
    output logic       clr,
    output logic [3:0] disp3,
    output logic [3:0] disp2,
    output logic [3:0] disp1,
    output logic [3:0] disp0,
    output logic       running,
    output logic       lap_active,
    output logic       done
);

    typedef enum logic [2:0] {StIdle, StRun, StPause, StLap, StDone} state_e;

    state_e            state_q, state_d;
    logic              up_q, up_d;
    logic              clr_q, clr_d;
    logic [15:0]       lap_q, lap_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              ss_prev_q, lap_prev_q, clr_prev_q;

    logic [15:0] live;
    logic        zero, cd_zero;
    logic        ss_ev, lap_ev, clr_ev;
    logic        ss_cmd, lap_cmd;
    logic        hold_expired;

    assign live    = {d3, d2, d1, d0};
    assign zero    = (live == 16'h0000);
    assign cd_zero = zero & ~up_q;

    assign ss_ev  = btn_ss  & ~ss_prev_q;
    assign lap_ev = btn_lap & ~lap_prev_q;
    assign clr_ev = btn_clr & ~clr_prev_q;

    // Same-cycle priority: clear beats start/stop beats lap.
    assign ss_cmd  = ss_ev & ~clr_ev;
    assign lap_cmd = lap_ev & ~clr_ev & ~ss_ev;

    assign hold_expired = (LAP_HOLD != '0) && (hold_q == HOLD_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            up_q       <= 1'b1;
            clr_q      <= 1'b0;
            lap_q      <= '0;
            hold_q     <= '0;
            ss_prev_q  <= 1'b0;
            lap_prev_q <= 1'b0;
            clr_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            up_q       <= up_d;
            clr_q      <= clr_d;
            lap_q      <= lap_d;
            hold_q     <= hold_d;
            ss_prev_q  <= btn_ss;
            lap_prev_q <= btn_lap;
            clr_prev_q <= btn_clr;
        end
    end

    always_comb begin
        state_d = state_q;
        up_d    = up_q;
        clr_d   = 1'b0;
        lap_d   = lap_q;
        hold_d  = hold_q;

        // Direction may only change while the datapath is not counting.
        if (state_q == StIdle || state_q == StPause) begin
            up_d = dir_sw;
        end

        if (state_q == StLap && LAP_HOLD != '0 && hold_q != '0) begin
            hold_d = hold_q - HOLD_W'(1);
        end

        if (clr_ev) begin
            state_d = StIdle;
            clr_d   = 1'b1;
            lap_d   = '0;
        end else begin
            unique case (state_q)
                StIdle, StPause: begin
                    if (ss_cmd) state_d = cd_zero ? StDone : StRun;
                end
                StRun: begin
                    if (ss_cmd) begin
                        state_d = StPause;
                    end else if (cd_zero) begin
                        state_d = StDone;
                    end else if (lap_cmd) begin
                        state_d = StLap;
                        lap_d   = live;
                        hold_d  = LAP_HOLD;
                    end
                end
                StLap: begin
                    if (ss_cmd) begin
                        state_d = StPause;
                    end else if (cd_zero) begin
                        state_d = StDone;
                    end else if (lap_cmd || hold_expired) begin
                        state_d = StRun;
                    end
                end
                StDone: begin
                    state_d = StDone;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // go is combinational so a countdown stops in the very cycle 0000 appears.
    assign running    = (state_q == StRun) || (state_q == StLap);
    assign go         = running & ~cd_zero;
    assign lap_active = (state_q == StLap);
    assign done       = (state_q == StDone);
    assign up         = up_q;
    assign clr        = clr_q;

    assign {disp3, disp2, disp1, disp0} = lap_active ? lap_q : live;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control sequencer for the 4-digit BCD stopwatch datapath (go/up inputs, d3..d0 outputs). Converts front-panel button levels into start/stop, lap-freeze, clear and direction commands. Drives the datapath's go/up/clr and muxes live or lap-frozen digits to the display. Auto-stops a countdown at 0000 so the datapath never underflows.

Parameters:
LAP_HOLD, 16'd0, lap-freeze timeout in clk cycles; 0 = hold until next lap press
HOLD_W, 16, width of lap-hold counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
btn_ss  in  1  start/stop button level (debounced), acts on rising edge
btn_lap  in  1  lap button level, acts on rising edge
btn_clr  in  1  clear button level, acts on rising edge
dir_sw  in  1  direction switch: 1 = up, 0 = down
d3,d2,d1,d0  in  4 each  live BCD digits from stopwatch datapath
go  out  1  datapath count enable
up  out  1  datapath direction
clr  out  1  datapath synchronous clear, 1-cycle pulse
disp3,disp2,disp1,disp0  out  4 each  digits to display
running  out  1  state is RUN or LAP
lap_active  out  1  display frozen
done  out  1  countdown reached zero

Behaviour:
- Reset: clk/rst is one clock; reset is asynchronous and active-high. Async reset forces state=IDLE, up=1, clr=0, lap regs=0, hold counter=0, edge-detect regs=0. go=0, done=0, lap_active=0, and disp=live digits.
- Edge detect: one register per button. Event = level & ~prev. Holding a button produces exactly one event.
- Event priority, same cycle: clr > ss > lap. Lower-priority events in that cycle are dropped.
- zero = (d3..d0 all 4'd0). cd_zero = zero & ~up.
- States: IDLE, RUN, PAUSE, LAP, DONE.
  - IDLE: ss -> RUN, unless cd_zero, then -> DONE.
  - RUN: ss -> PAUSE. lap -> LAP, captures d3..d0 into lap regs and loads hold counter = LAP_HOLD. cd_zero -> DONE.
  - LAP: datapath keeps counting. ss -> PAUSE and lap_active clears. lap -> RUN. LAP_HOLD≠0 and counter reaches 1 -> RUN. cd_zero -> DONE.
  - PAUSE: ss -> RUN, unless cd_zero, then -> DONE. lap is ignored.
  - DONE: ss -> DONE, no effect. lap is ignored.
  - Any state: clr -> IDLE, clr pulses high the next cycle (registered, 1 cycle), lap regs cleared.
- go = (state==RUN | state==LAP) & ~cd_zero. This is combinational, so go drops in the same cycle zero is observed in down mode; no extra tick.
- up is registered from dir_sw only while state is IDLE or PAUSE. It is frozen in RUN, LAP and DONE.
- done = (state==DONE). running = RUN|LAP. lap_active = (state==LAP).
- disp = lap regs when lap_active, else d3..d0 combinationally.
- Hold counter decrements once per cycle in LAP when LAP_HOLD≠0. Re-entering LAP reloads it.
- Reset mid-operation: immediate IDLE, go=0 asynchronously.
- Up count at 9999: the controller does not stop; the datapath wrap is the datapath's concern.

Test Plan:
- Reset, dir_sw=1, pulse btn_ss (high 5 cycles) -> one event. go=1 and running=1 from the cycle after the edge. Second press -> go=0, state PAUSE.
- RUN with digits 0123, pulse btn_lap -> lap_active=1, disp=0123 while d advances to 0150. Pulse btn_lap again -> disp tracks live digits.
- LAP_HOLD=10: enter LAP -> lap_active drops exactly 10 cycles after entry and the state returns to RUN. go stays 1 throughout.
- PAUSE, set dir_sw=0, start with d=0002 -> go=1. When d=0000, go=0 in the same cycle and done=1 next cycle. btn_ss after that -> no change.
- Pulse btn_clr and btn_ss on the same edge while in RUN -> state IDLE, clr high exactly 1 cycle, go=0, lap regs=0.
- Assert rst mid-LAP -> go=0, lap_active=0 and up=1 immediately without a clock edge. After release, start in IDLE.
